// File: rtl/instr_pkg.sv
// Shared definitions for the writable instruction store.
//   INSTR_ADDR_W  : default address width (depth = 2**INSTR_ADDR_W words)
//   INSTR_WORD_W  : default instruction width in bits
//   store_state_e : store FSM states
// The defaults are shared with the fetch stage and the assembler-side tools.
package instr_pkg;

    localparam int unsigned INSTR_ADDR_W = 12;
    localparam int unsigned INSTR_WORD_W = 9;

    // IDLE: no valid program resident; LOAD: program streaming in;
    // RUN: complete program resident, fetch enabled.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } store_state_e;

endpackage : instr_pkg

// File: rtl/instr_store_if.sv
// Load and fetch bus of the instruction store.
//   Load side : load_start/load_base/load_len start a load; ld_valid/ld_data/
//               ld_ready move words; load_done, load_csum, busy and prog_ok
//               report progress.
//   Fetch side: fetch_en/prog_ctr request a word; mach_code/mach_valid return
//               it one cycle later.
// master = loader/fetch stage side, slave = the store.
interface instr_store_if #(
    parameter int unsigned D = 12,
    parameter int unsigned W = 9
);
    logic         load_start;
    logic [D-1:0] load_base;
    logic [D:0]   load_len;
    logic         ld_valid;
    logic [W-1:0] ld_data;
    logic         ld_ready;
    logic         load_done;
    logic [W-1:0] load_csum;
    logic         busy;
    logic         prog_ok;
    logic         fetch_en;
    logic [D-1:0] prog_ctr;
    logic [W-1:0] mach_code;
    logic         mach_valid;

    modport master (
        output load_start, load_base, load_len, ld_valid, ld_data,
               fetch_en, prog_ctr,
        input  ld_ready, load_done, load_csum, busy, prog_ok,
               mach_code, mach_valid
    );

    modport slave (
        input  load_start, load_base, load_len, ld_valid, ld_data,
               fetch_en, prog_ctr,
        output ld_ready, load_done, load_csum, busy, prog_ok,
               mach_code, mach_valid
    );
endinterface : instr_store_if

// File: rtl/instr_ram.sv
// Single-port instruction array, 2**D x W, synchronous write and synchronous
// read. The array itself has no reset; only the read-data register does, so
// the fetched word reads as zero out of reset.
//   clk   : clock
//   rst_n : async active-low reset of the read register
//   we    : write mem[addr] = wdata
//   re    : rdata <= mem[addr]; rdata holds when re = 0
//   addr  : shared read/write address (we and re are never both set)
//   wdata : write data
//   rdata : registered read data
module instr_ram #(
    parameter int unsigned D = 12,
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic         re,
    input  logic [D-1:0] addr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem_r [2**D];
    logic [W-1:0] rdata_r;

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register; holds the last fetched word between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule : instr_ram

// File: rtl/instr_store.sv
// Writable instruction store. A loader streams a program in over a valid/ready
// port (auto-incrementing, wrapping address, running XOR checksum); the fetch
// stage reads it with one cycle of latency once the whole program is resident.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-low reset
//   bus   : load and fetch bus (slave side), see instr_store_if
module instr_store
    import instr_pkg::*;
#(
    parameter int unsigned D = INSTR_ADDR_W,
    parameter int unsigned W = INSTR_WORD_W
) (
    input  logic          clk,
    input  logic          reset,
    instr_store_if.slave  bus
);

    localparam logic [D-1:0] ADDR_ONE = {{(D-1){1'b0}}, 1'b1};
    localparam logic [D:0]   LEN_ZERO = {(D+1){1'b0}};
    localparam logic [D:0]   LEN_ONE  = {{D{1'b0}}, 1'b1};

    // Running checksum step: fold one accepted word into the accumulator.
    function automatic logic [W-1:0] csum_fold(input logic [W-1:0] acc,
                                               input logic [W-1:0] word);
        return acc ^ word;
    endfunction

    store_state_e state_r;
    store_state_e state_nxt_s;
    logic [D-1:0] addr_r;
    logic [D:0]   remaining_r;
    logic [W-1:0] csum_r;
    logic         done_r;
    logic         mach_valid_r;

    logic         start_s;
    logic         empty_load_s;
    logic         ld_ready_s;
    logic         beat_s;
    logic         last_beat_s;
    logic         fetch_s;
    logic [D-1:0] ram_addr_s;
    logic [W-1:0] ram_rdata_s;

    // A load may only start outside LOAD; a start during LOAD is dropped.
    assign start_s      = bus.load_start && (state_r != LOAD);
    assign empty_load_s = (bus.load_len == LEN_ZERO);
    // ready depends only on state and the remaining count, never on ld_valid.
    assign ld_ready_s   = (state_r == LOAD) && (remaining_r != LEN_ZERO);
    assign beat_s       = bus.ld_valid && ld_ready_s;
    assign last_beat_s  = beat_s && (remaining_r == LEN_ONE);
    assign fetch_s      = (state_r == RUN) && bus.fetch_en;
    // Writes only happen in LOAD and reads only in RUN, so one port suffices.
    assign ram_addr_s   = (state_r == LOAD) ? addr_r : bus.prog_ctr;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, RUN: begin
                if (bus.load_start) begin
                    state_nxt_s = empty_load_s ? RUN : LOAD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            LOAD: begin
                if (last_beat_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Load datapath: write address, remaining count, checksum, done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r      <= {D{1'b0}};
            remaining_r <= LEN_ZERO;
            csum_r      <= {W{1'b0}};
            done_r      <= 1'b0;
        end else if (start_s) begin
            addr_r      <= bus.load_base;
            remaining_r <= bus.load_len;
            csum_r      <= {W{1'b0}};
            // An empty load completes on the same edge that starts it.
            done_r      <= empty_load_s;
        end else if (beat_s) begin
            addr_r      <= addr_r + ADDR_ONE;
            remaining_r <= remaining_r - LEN_ONE;
            csum_r      <= csum_fold(csum_r, bus.ld_data);
            done_r      <= last_beat_s;
        end else begin
            done_r      <= 1'b0;
        end
    end

    // Fetch-valid flag tracks whether the read register was updated last edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mach_valid_r <= 1'b0;
        end else begin
            mach_valid_r <= fetch_s;
        end
    end

    instr_ram #(
        .D (D),
        .W (W)
    ) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (beat_s),
        .re    (fetch_s),
        .addr  (ram_addr_s),
        .wdata (bus.ld_data),
        .rdata (ram_rdata_s)
    );

    assign bus.ld_ready   = ld_ready_s;
    assign bus.busy       = (state_r == LOAD);
    assign bus.prog_ok    = (state_r == RUN);
    assign bus.load_done  = done_r;
    assign bus.load_csum  = csum_r;
    assign bus.mach_code  = ram_rdata_s;
    assign bus.mach_valid = mach_valid_r;

endmodule : instr_store

// File: tb/tb_instr_store.sv
// Directed bench for instr_store, built with D = 4, W = 9.
module tb_instr_store;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    instr_store_if #(.D(4), .W(9)) bus ();

    instr_store #(.D(4), .W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [3:0] base, input logic [4:0] len);
        bus.load_start = 1'b1;
        bus.load_base  = base;
        bus.load_len   = len;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic stream(input logic [8:0] w);
        bus.ld_valid = 1'b1;
        bus.ld_data  = w;
        chk("ld_ready_beat", 32'(bus.ld_ready), 32'h1);
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic fetch(input logic [3:0] a, input logic [8:0] exp);
        bus.fetch_en = 1'b1;
        bus.prog_ctr = a;
        tick();
        chk("fetch_valid", 32'(bus.mach_valid), 32'h1);
        chk("fetch_code", 32'(bus.mach_code), 32'(exp));
        bus.fetch_en = 1'b0;
    endtask

    logic [8:0] wa [4];
    logic [8:0] wb [4];
    logic [8:0] wc [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        wa[0] = 9'h0FE; wa[1] = 9'h066; wa[2] = 9'h07A; wa[3] = 9'h1DE;
        wb[0] = 9'h011; wb[1] = 9'h122; wb[2] = 9'h033; wb[3] = 9'h144;
        wc[0] = 9'h1A1; wc[1] = 9'h0B2; wc[2] = 9'h1C3; wc[3] = 9'h0D4;
        reset          = 1'b0;
        bus.load_start = 1'b0;
        bus.load_base  = 4'd0;
        bus.load_len   = 5'd0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = 9'd0;
        bus.fetch_en   = 1'b0;
        bus.prog_ctr   = 4'd0;

        // Reset values.
        #22;
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_prog_ok", 32'(bus.prog_ok), 32'h0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'h0);
        chk("rst_load_done", 32'(bus.load_done), 32'h0);
        chk("rst_csum", 32'(bus.load_csum), 32'h0);
        chk("rst_mach_valid", 32'(bus.mach_valid), 32'h0);
        chk("rst_mach_code", 32'(bus.mach_code), 32'h0);
        reset = 1'b1;
        tick();

        // Fetch without a program is refused.
        bus.fetch_en = 1'b1;
        bus.prog_ctr = 4'd0;
        tick();
        chk("idle_fetch_valid", 32'(bus.mach_valid), 32'h0);
        chk("idle_prog_ok", 32'(bus.prog_ok), 32'h0);
        chk("idle_mach_code", 32'(bus.mach_code), 32'h0);
        bus.fetch_en = 1'b0;

        // Continuous load of 4 words at base 0.
        start_load(4'd0, 5'd4);
        chk("a_busy", 32'(bus.busy), 32'h1);
        chk("a_csum_clr", 32'(bus.load_csum), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("a_done_early", 32'(bus.load_done), 32'h0);
            stream(wa[i]);
        end
        chk("a_done", 32'(bus.load_done), 32'h1);
        chk("a_busy_end", 32'(bus.busy), 32'h0);
        chk("a_prog_ok", 32'(bus.prog_ok), 32'h1);
        chk("a_ready_end", 32'(bus.ld_ready), 32'h0);
        chk("a_csum", 32'(bus.load_csum), 32'h13C);
        // First fetch right on the edge after the final beat.
        fetch(4'd0, wa[0]);
        chk("a_done_pulse", 32'(bus.load_done), 32'h0);
        for (int i = 1; i < 4; i++) begin
            fetch(4'(i), wa[i]);
        end
        tick();
        chk("a_idle_valid", 32'(bus.mach_valid), 32'h0);
        chk("a_code_hold", 32'(bus.mach_code), 32'h1DE);

        // Load with ld_valid every other cycle at base 4.
        start_load(4'd4, 5'd4);
        for (int i = 0; i < 4; i++) begin
            stream(wb[i]);
            if (i == 3) begin
                chk("b_done", 32'(bus.load_done), 32'h1);
                chk("b_busy_end", 32'(bus.busy), 32'h0);
            end else begin
                chk("b_busy", 32'(bus.busy), 32'h1);
                tick();
                chk("b_done_gap", 32'(bus.load_done), 32'h0);
            end
        end
        chk("b_csum", 32'(bus.load_csum), 32'h044);
        for (int i = 0; i < 4; i++) begin
            fetch(4'(4 + i), wb[i]);
        end
        fetch(4'd1, wa[1]);

        // Load wrapping past the top of memory.
        start_load(4'd14, 5'd4);
        for (int i = 0; i < 4; i++) begin
            stream(wc[i]);
        end
        chk("c_done", 32'(bus.load_done), 32'h1);
        chk("c_csum", 32'(bus.load_csum), 32'h004);
        fetch(4'd14, wc[0]);
        fetch(4'd15, wc[1]);
        fetch(4'd0, wc[2]);
        fetch(4'd1, wc[3]);
        fetch(4'd2, wa[2]);

        // Empty load.
        start_load(4'd3, 5'd0);
        chk("z_done", 32'(bus.load_done), 32'h1);
        chk("z_busy", 32'(bus.busy), 32'h0);
        chk("z_prog_ok", 32'(bus.prog_ok), 32'h1);
        chk("z_csum", 32'(bus.load_csum), 32'h0);
        tick();
        chk("z_done_pulse", 32'(bus.load_done), 32'h0);

        // load_start during LOAD is ignored.
        start_load(4'd8, 5'd3);
        bus.load_start = 1'b1;
        bus.load_base  = 4'd0;
        bus.load_len   = 5'd1;
        stream(9'h055);
        chk("s_busy1", 32'(bus.busy), 32'h1);
        stream(9'h0AA);
        chk("s_busy2", 32'(bus.busy), 32'h1);
        chk("s_done2", 32'(bus.load_done), 32'h0);
        stream(9'h1FF);
        bus.load_start = 1'b0;
        chk("s_done", 32'(bus.load_done), 32'h1);
        chk("s_csum", 32'(bus.load_csum), 32'h100);
        fetch(4'd8, 9'h055);
        fetch(4'd9, 9'h0AA);
        fetch(4'd10, 9'h1FF);
        fetch(4'd0, wc[2]);

        // Reset in the middle of a load.
        start_load(4'd0, 5'd4);
        stream(9'h1EE);
        stream(9'h0DD);
        #2;
        reset = 1'b0;
        #1;
        chk("r_busy", 32'(bus.busy), 32'h0);
        chk("r_prog_ok", 32'(bus.prog_ok), 32'h0);
        chk("r_ld_ready", 32'(bus.ld_ready), 32'h0);
        chk("r_csum", 32'(bus.load_csum), 32'h0);
        #3;
        reset = 1'b1;
        bus.fetch_en = 1'b1;
        bus.prog_ctr = 4'd0;
        tick();
        chk("r_fetch_valid1", 32'(bus.mach_valid), 32'h0);
        tick();
        chk("r_fetch_valid2", 32'(bus.mach_valid), 32'h0);
        chk("r_prog_ok2", 32'(bus.prog_ok), 32'h0);
        bus.fetch_en = 1'b0;
        start_load(4'd0, 5'd1);
        stream(9'h123);
        chk("r_done", 32'(bus.load_done), 32'h1);
        fetch(4'd0, 9'h123);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_instr_store
